// File: rtl/pmbist_response_analyzer.sv
// PMBIST read-side response analyzer: two-stage compare pipeline, sticky fail/overflow
// flags, a saturating fail counter and a first-word-fall-through log of failing addresses.
module pmbist_response_analyzer #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LOG_DEPTH  = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_in,
  input  logic                  cmp_en_in,
  input  logic [ADDR_WIDTH-1:0] tas_in,
  input  logic [DATA_WIDTH-1:0] exp_in,
  input  logic [DATA_WIDTH-1:0] rd_data_in,
  output logic                  fail_out,
  output logic [CNT_WIDTH-1:0]  fail_cnt_out,
  output logic                  ovf_out,
  output logic                  log_valid_out,
  output logic [ADDR_WIDTH-1:0] log_addr_out,
  output logic [DATA_WIDTH-1:0] log_syn_out,
  input  logic                  log_ready_in
);

  localparam int PTR_W = $clog2(LOG_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(LOG_DEPTH);
  localparam logic [PTR_W:0] OCC_ONE = (PTR_W+1)'(1);

  logic                  s1_valid;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [DATA_WIDTH-1:0] s1_exp;
  logic [DATA_WIDTH-1:0] s1_rd;

  logic                  s2_valid;
  logic [ADDR_WIDTH-1:0] s2_addr;
  logic [DATA_WIDTH-1:0] s2_syn;

  logic [ADDR_WIDTH-1:0] addr_mem [LOG_DEPTH];
  logic [DATA_WIDTH-1:0] syn_mem  [LOG_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;

  logic                  fail_q;
  logic                  ovf_q;
  logic [CNT_WIDTH-1:0]  cnt_q;

  logic mis;
  logic full;
  logic not_empty;
  logic pop;
  logic push;
  logic drop;

  // Data fields load every cycle; only the valid bits are cleared by clr_in.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_exp   <= '0;
      s1_rd    <= '0;
      s2_valid <= 1'b0;
      s2_addr  <= '0;
      s2_syn   <= '0;
    end else begin
      s1_valid <= cmp_en_in & ~clr_in;
      s1_addr  <= tas_in;
      s1_exp   <= exp_in;
      s1_rd    <= rd_data_in;
      s2_valid <= s1_valid & ~clr_in;
      s2_addr  <= s1_addr;
      s2_syn   <= s1_exp ^ s1_rd;
    end
  end

  always_comb begin
    mis       = s2_valid && (s2_syn != '0);
    full      = (count == DEPTH_C);
    not_empty = (count != '0);
    pop       = not_empty & log_ready_in;
    push      = mis & (~full | pop);
    drop      = mis & full & ~pop;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr_in) begin
      fail_q <= 1'b0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (mis) begin
        fail_q <= 1'b1;
        if (!(&cnt_q)) cnt_q <= cnt_q + 1'b1;
      end
      if (drop) ovf_q <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + OCC_ONE;
        2'b01:   count <= count - OCC_ONE;
        default: count <= count;
      endcase
    end
  end

  // Log storage needs no reset: pointers and occupancy decide what is visible.
  always_ff @(posedge clk) begin
    if (push && !clr_in) begin
      addr_mem[wr_ptr] <= s2_addr;
      syn_mem[wr_ptr]  <= s2_syn;
    end
  end

  assign fail_out      = fail_q;
  assign ovf_out       = ovf_q;
  assign fail_cnt_out  = cnt_q;
  assign log_valid_out = not_empty;
  assign log_addr_out  = not_empty ? addr_mem[rd_ptr] : '0;
  assign log_syn_out   = not_empty ? syn_mem[rd_ptr]  : '0;

endmodule
